// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that writes big-endian words into instruction memory and holds the core until the image checks out
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR} state_t;
  state_t            state, state_nx;
  logic [15:0]       len;
  logic [15:0]       len_n;
  logic [7:0]        xor_acc;
  logic [23:0]       word_reg;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   word_idx, idx_nx;
  logic              accept, restart, last_word, oversize;
  assign len_n     = {len[15:8], rx_data};
  assign idx_nx    = word_idx + 1'b1;
  assign last_word = 32'(idx_nx) == 32'(len);
  assign oversize  = 32'(len_n) > (32'd1 << ADDR_W);
  // state register; reset mid-frame abandons the frame
  always_ff @(posedge clk)
    state <= !reset ? IDLE : state_nx;
  // next state and status outputs; the word write overlaps the next byte so DATA never stalls
  always_comb begin
    busy     = state inside {LEN_HI, LEN_LO, DATA, CSUM};
    rx_ready = busy;
    done     = state == DONE;
    error    = state == ERR;
    cpu_hold = state != DONE;
    restart  = start && !busy;
    accept   = rx_valid && rx_ready;
    state_nx = restart ? LEN_HI : state;
    if (accept)
      case (state)
        LEN_HI:  state_nx = LEN_LO;
        LEN_LO:  state_nx = oversize ? ERR : (len_n == 16'd0 ? CSUM : DATA);
        DATA:    state_nx = (byte_cnt == 2'd3 && last_word) ? CSUM : DATA;
        CSUM:    state_nx = rx_data == xor_acc ? DONE : ERR;
        default: state_nx = state;
      endcase
  end
  // datapath: length capture, word assembly, checksum accumulation and memory write
  always_ff @(posedge clk)
    if (!reset) begin
      len          <= '0;
      xor_acc      <= '0;
      word_reg     <= '0;
      byte_cnt     <= '0;
      word_idx     <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= ADDR_W'(BASE_ADDR);
      imem_wdata   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (restart) begin
        xor_acc      <= '0;
        word_idx     <= '0;
        byte_cnt     <= '0;
        words_loaded <= '0;
      end
      if (accept && state == LEN_HI) len[15:8] <= rx_data;
      if (accept && state == LEN_LO) len[7:0] <= rx_data;
      if (accept && state == DATA) begin
        xor_acc  <= xor_acc ^ rx_data;
        byte_cnt <= byte_cnt + 1'b1;
        word_reg <= {word_reg[15:0], rx_data};
        if (byte_cnt == 2'd3) begin
          imem_we      <= 1'b1;
          imem_wdata   <= {word_reg, rx_data};
          imem_addr    <= ADDR_W'(BASE_ADDR) + word_idx[ADDR_W-1:0];
          word_idx     <= idx_nx;
          words_loaded <= idx_nx;
        end
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of framing, checksum, length limits, backpressure, reset and address wrap
module tb_imem_loader;
  logic       clk = 0, reset = 0, start = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic       rx_ready, imem_we, cpu_hold, busy, done, error;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0] words_loaded;
  logic       rr_w, we_w, hold_w, busy_w, done_w, err_w;
  logic [7:0] addr_w;
  logic [31:0] wdata_w;
  logic [8:0] wl_w;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] fr [0:15];
  int fr_n = 0;
  logic [7:0]  wa [$], wa_w [$];
  logic [31:0] wd [$], wd_w [$];

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );
  imem_loader #(.ADDR_W(8), .BASE_ADDR(255)) dut_w (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rr_w), .imem_we(we_w), .imem_addr(addr_w), .imem_wdata(wdata_w),
    .cpu_hold(hold_w), .busy(busy_w), .done(done_w), .error(err_w), .words_loaded(wl_w)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin wa.push_back(imem_addr); wd.push_back(imem_wdata); end
    if (we_w) begin wa_w.push_back(addr_w); wd_w.push_back(wdata_w); end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit bp);
    if (bp) repeat ($urandom_range(0, 2)) begin
      rx_valid = 0;
      rx_data  = 8'($urandom);
      tick();
    end
    rx_data  = b;
    rx_valid = 1;
    for (int n = 0; n < 50 && !rx_ready; n++) tick();
    if (!rx_ready) chk("ready_timeout", 0, 1);
    tick();
    rx_valid = 0;
  endtask

  task automatic pulse_start;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic clear_q;
    wa.delete(); wd.delete(); wa_w.delete(); wd_w.delete();
  endtask

  task automatic set_two(input logic [7:0] cs);
    fr[0] = 8'h00; fr[1] = 8'h02;
    fr[2] = 8'h20; fr[3] = 8'h08; fr[4] = 8'h00; fr[5] = 8'h05;
    fr[6] = 8'h21; fr[7] = 8'h09; fr[8] = 8'h00; fr[9] = 8'h03;
    fr[10] = cs;
    fr_n = 11;
  endtask

  task automatic send_frame(input bit bp);
    for (int i = 0; i < fr_n; i++) send(fr[i], bp);
  endtask

  task automatic chk_two(input string tag);
    chk({tag, "_nwrites"}, wa.size(), 2);
    if (wa.size() == 2) begin
      chk({tag, "_addr0"}, wa[0], 8'h00);
      chk({tag, "_data0"}, wd[0], 32'h20080005);
      chk({tag, "_addr1"}, wa[1], 8'h01);
      chk({tag, "_data1"}, wd[1], 32'h21090003);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 8'h00);
    chk({tag, "_addr_w"}, addr_w, 8'hff);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_hold"}, cpu_hold, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_wl"}, words_loaded, 0);
  endtask

  initial begin
    tick(); tick();
    chk_reset("rst");
    reset = 1;
    tick();

    pulse_start();
    chk("t1_busy", busy, 1);
    chk("t1_ready", rx_ready, 1);
    clear_q();
    set_two(8'h06);
    for (int i = 0; i < fr_n; i++) begin
      send(fr[i], 0);
      if (i == 5) begin
        chk("t1_we0", imem_we, 1);
        chk("t1_we0_addr", imem_addr, 8'h00);
        chk("t1_we0_data", imem_wdata, 32'h20080005);
        chk("t1_we0_wl", words_loaded, 1);
      end
      if (i == 6) chk("t1_we_pulse", imem_we, 0);
      if (i == 9) begin
        chk("t1_we1", imem_we, 1);
        chk("t1_we1_addr", imem_addr, 8'h01);
        chk("t1_we1_data", imem_wdata, 32'h21090003);
        chk("t1_we1_wl", words_loaded, 2);
      end
    end
    chk("t1_done", done, 1);
    chk("t1_hold", cpu_hold, 0);
    chk("t1_error", error, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_wl", words_loaded, 2);
    chk_two("t1");

    pulse_start();
    chk("t2_hold_rise", cpu_hold, 1);
    chk("t2_done_drop", done, 0);
    chk("t2_wl_clear", words_loaded, 0);
    clear_q();
    set_two(8'h07);
    send_frame(0);
    chk("t2_error", error, 1);
    chk("t2_done", done, 0);
    chk("t2_hold", cpu_hold, 1);
    chk("t2_wl", words_loaded, 2);
    chk_two("t2");

    pulse_start();
    chk("t3_error_drop", error, 0);
    clear_q();
    send(8'h01, 0);
    send(8'h01, 0);
    chk("t3_error", error, 1);
    chk("t3_ready", rx_ready, 0);
    chk("t3_busy", busy, 0);
    tick(); tick(); tick();
    chk("t3_nwrites", wa.size(), 0);

    pulse_start();
    clear_q();
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    chk("t4_done", done, 1);
    chk("t4_wl", words_loaded, 0);
    chk("t4_nwrites", wa.size(), 0);

    pulse_start();
    chk("t5_hold_rise", cpu_hold, 1);
    chk("t5_done_drop", done, 0);
    clear_q();
    fr[0] = 8'h00; fr[1] = 8'h01; fr[2] = 8'haa; fr[3] = 8'hbb; fr[4] = 8'hcc; fr[5] = 8'hdd; fr[6] = 8'h00;
    fr_n = 7;
    send_frame(0);
    chk("t5_done", done, 1);
    chk("t5_wl", words_loaded, 1);
    chk("t5_nwrites", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("t5_addr", wa[0], 8'h00);
      chk("t5_data", wd[0], 32'haabbccdd);
    end

    pulse_start();
    clear_q();
    set_two(8'h06);
    send_frame(1);
    chk("t6_done", done, 1);
    chk("t6_wl", words_loaded, 2);
    chk_two("t6");

    pulse_start();
    for (int i = 0; i < 7; i++) send(fr[i], 0);
    chk("t7_busy", busy, 1);
    reset = 0;
    tick();
    chk_reset("t7_rst");
    reset = 1;
    tick();
    chk("t7_idle_busy", busy, 0);
    pulse_start();
    clear_q();
    send_frame(0);
    chk("t7_done", done, 1);
    chk_two("t7");

    pulse_start();
    clear_q();
    send_frame(0);
    chk("t8_done_w", done_w, 1);
    chk("t8_wl_w", wl_w, 2);
    chk("t8_nwrites_w", wa_w.size(), 2);
    if (wa_w.size() == 2) begin
      chk("t8_addr0_w", wa_w[0], 8'hff);
      chk("t8_data0_w", wd_w[0], 32'h20080005);
      chk("t8_addr1_w", wa_w[1], 8'h00);
      chk("t8_data1_w", wd_w[1], 32'h21090003);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the pipelined RISC core. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into the instruction memory's write port. The fetch stage is the reader of that memory. The loader holds the core in reset until a complete, checksum-verified image has been written.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `BASE_ADDR`, default 0: word address of the first loaded word.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE and ERR.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader can accept a byte.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address; equals BASE_ADDR + word index.
- `imem_wdata`  out  32  assembled instruction word.
- `cpu_hold`  out  1  drives the core's reset; high means the core is held.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  image loaded and verified; level signal.
- `error`  out  1  frame rejected; level signal.
- `words_loaded`  out  ADDR_W+1  count of words written in the current frame.

## Operation
- Frame layout: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4N payload bytes (MSB first per word), then 1 checksum byte. The checksum is the XOR of all payload bytes.
- Transfer rule: a byte is accepted on a rising edge when `rx_valid && rx_ready`. `rx_ready` is high only in LEN_HI, LEN_LO, DATA and CSUM.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- IDLE -> LEN_HI on `start`.
- LEN_HI -> LEN_LO on byte acceptance.
- LEN_LO on byte acceptance:
  - N > 2^ADDR_W -> ERR.
  - N = 0 -> CSUM.
  - otherwise -> DATA.
- DATA:
  - A byte counter (0..3) shifts each byte into a word register.
  - On the 4th byte, the word is written and the word index increments.
  - After word N is written -> CSUM.
- CSUM on byte acceptance:
  - byte equals the running XOR -> DONE.
  - otherwise -> ERR.
- DONE/ERR: remain in the state until `start` (-> LEN_HI) or reset. On `start`, the running XOR, word index, byte counter and `words_loaded` clear, and `done`/`error` drop in the same cycle.
- `start` in LEN_HI..CSUM is ignored.
- `cpu_hold` is 0 only in DONE. A restart from DONE re-asserts the hold on the cycle the state leaves DONE.
- Words already written before an ERR are not rolled back. `words_loaded` shows how many were written.
- Address arithmetic is ADDR_W bits, modulo 2^ADDR_W. BASE_ADDR + index wraps silently. N = 2^ADDR_W is legal and fills the whole memory.
- `busy` = state in {LEN_HI, LEN_LO, DATA, CSUM}.

## Timing
- Reset values: IDLE; `rx_ready`=0, `imem_we`=0, `imem_addr`=BASE_ADDR, `imem_wdata`=0, `cpu_hold`=1, `busy`=0, `done`=0, `error`=0, `words_loaded`=0.
- Reset mid-frame returns to IDLE on the next edge; any partial word is discarded.
- Write latency: `imem_we` is high for exactly the one cycle after the edge that accepted the 4th byte. `imem_addr` and `imem_wdata` are stable during that cycle.
- `words_loaded` increments in the same cycle `imem_we` is high.
- `rx_ready` may stay high back-to-back, so one byte can be accepted per cycle.
- The word write overlaps acceptance of the next word's first byte without stalling.
- Each of `done`, `error` and `cpu_hold` changes one cycle after the edge that accepts the checksum byte.
- With `rx_valid` low, state and counters hold; no timeout.

## Test plan
- **Two-word load:** reset, `start`, bytes 00 02 20 08 00 05 21 09 00 03 06 at one per cycle.
  - Writes 0x20080005 at address 0 and 0x21090003 at address 1.
  - Then `done`=1, `cpu_hold`=0, `words_loaded`=2.
- **Bad checksum:** same frame with checksum 07 -> both words written, then `error`=1, `done`=0, `cpu_hold`=1.
- **Oversize count (ADDR_W=8):** length 01 01 -> ERR after LEN_LO, `imem_we` never asserted, `rx_ready`=0.
- **Empty frame:** length 00 00, checksum 00 -> DONE with `words_loaded`=0 and no writes.
- **Backpressure and mid-frame reset:**
  - `rx_valid` toggled randomly during the two-word load -> identical writes and result.
  - Reset after 5 payload bytes -> IDLE, reset values on all outputs; a following full frame loads correctly.
- **Restart and wrap:** `start` in DONE -> `cpu_hold` rises next cycle, and a new 1-word frame writes address 0. With BASE_ADDR=255 and N=2, the writes go to addresses 255 and 0.
